// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder, a carry flip-flop closing the loop,
// and a start/busy/done handshake toward the control sequencer.

module FullAdder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic             fa_sum, fa_carry;
    logic             accept, running, last_bit;
    logic [WIDTH-1:0] sum_next;

    FullAdder u_fa (
        .a    (shift_a_q[0]),
        .b    (shift_b_q[0]),
        .c    (carry_q),
        .sum  (fa_sum),
        .carry(fa_carry)
    );

    assign accept   = start && (state_q != RUN);
    assign running  = (state_q == RUN);
    assign last_bit = (count_q == CW'(WIDTH - 1));

    // The final sum bit goes straight into sum_q, so the partial-sum shifter
    // only needs to keep the WIDTH-1 bits already produced.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_next = fa_sum;
        end else begin : g_wn
            logic [WIDTH-2:0] shift_s_q, shift_s_d;

            assign sum_next = {fa_sum, shift_s_q};

            always_comb begin
                shift_s_d = shift_s_q;
                if (accept) begin
                    shift_s_d = '0;
                end else if (running) begin
                    shift_s_d = sum_next[WIDTH-1:1];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    shift_s_q <= '0;
                end else begin
                    shift_s_q <= shift_s_d;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        shift_a_d   = shift_a_q;
        shift_b_d   = shift_b_q;
        count_d     = count_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    carry_d   = carry_in;
                    count_d   = '0;
                    state_d   = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                carry_d   = fa_carry;
                count_d   = count_q + 1'b1;
                if (last_bit) begin
                    sum_d       = sum_next;
                    carry_out_d = fa_carry;
                    overflow_d  = carry_q ^ fa_carry;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_a_q   <= '0;
            shift_b_q   <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_a_q   <= shift_a_d;
            shift_b_q   <= shift_b_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1: directed table,
// multi-cycle handshake corner cases, and randomized arithmetic regression.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset8, start8, cin8, busy8, done8, co8, ov8;
    logic [7:0] a8, b8, sum8;
    logic       reset1, start1, cin1, busy1, done1, co1, ov1;
    logic [0:0] a1, b1, sum1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .a(a8), .b(b8),
        .carry_in(cin8), .busy(busy8), .done(done8), .sum(sum8),
        .carry_out(co8), .overflow(ov8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .a(a1), .b(b1),
        .carry_in(cin1), .busy(busy1), .done(done1), .sum(sum1),
        .carry_out(co1), .overflow(ov1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       co;
        logic       ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer addition, overflow from operand/result sign bits.
    function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       v;
        t = 9'(x) + 9'(y) + 9'(c);
        v = (x[7] == y[7]) && (t[7] != x[7]);
        return {v, t};
    endfunction

    function automatic logic [2:0] ref1(input logic x, input logic y, input logic c);
        logic [1:0] t;
        logic       v;
        t = 2'(x) + 2'(y) + 2'(c);
        v = (x == y) && (t[0] != x);
        return {v, t};
    endfunction

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int bcyc, output int dk);
        @(negedge clk);
        a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        bcyc = 0;
        dk = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy8) bcyc++;
            if (done8) begin
                dk = k;
                break;
            end
            @(negedge clk);
        end
        s = sum8; co = co8; ov = ov8;
    endtask

    task automatic run1(input logic ta, input logic tb_, input logic tc,
                        output logic s, output logic co, output logic ov,
                        output int bcyc, output int dk);
        @(negedge clk);
        a1 = ta; b1 = tb_; cin1 = tc; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        bcyc = 0;
        dk = 0;
        for (int k = 1; k <= 10; k++) begin
            if (busy1) bcyc++;
            if (done1) begin
                dk = k;
                break;
            end
            @(negedge clk);
        end
        s = sum1[0]; co = co1; ov = ov1;
    endtask

    initial begin
        vec_t       tbl[5];
        logic [7:0] s;
        logic       co, ov, s1;
        logic [9:0] r8;
        logic [2:0] r;
        int         bcyc, dk, pulses, k1, m;
        logic [7:0] ra, rb;
        logic       rc, stable;

        tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        reset8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        reset1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        reset8 = 1'b0; reset1 = 1'b0;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_co", 32'(co8), 32'd0);
        check("rst_ov", 32'(ov8), 32'd0);
        check("rst1_state", 32'({busy1, done1, sum1, co1, ov1}), 32'd0);

        foreach (tbl[i]) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].cin, s, co, ov, bcyc, dk);
            check($sformatf("tbl%0d_sum", i), 32'(s), 32'(tbl[i].sum));
            check($sformatf("tbl%0d_co", i), 32'(co), 32'(tbl[i].co));
            check($sformatf("tbl%0d_ov", i), 32'(ov), 32'(tbl[i].ov));
            check($sformatf("tbl%0d_busy_cycles", i), 32'(bcyc), 32'd8);
            check($sformatf("tbl%0d_done_cycle", i), 32'(dk), 32'd9);
            @(negedge clk);
            check($sformatf("tbl%0d_done_pulse", i), 32'(done8), 32'd0);
        end

        // Start during RUN must be ignored, along with operand changes.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        pulses = 0;
        s = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
            end
            if (k == 4) start8 = 1'b0;
            if (done8) begin
                pulses++;
                s = sum8;
            end
            @(negedge clk);
        end
        check("ignore_start_pulses", 32'(pulses), 32'd1);
        check("ignore_start_sum", 32'(s), 32'h8D);

        // Reset in the middle of RUN aborts with no done pulse.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset8 = 1'b1;
        @(negedge clk);
        reset8 = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_co", 32'(co8), 32'd0);
        check("abort_ov", 32'(ov8), 32'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run8(8'h10, 8'h20, 1'b0, s, co, ov, bcyc, dk);
        check("after_abort_sum", 32'(s), 32'h30);
        check("after_abort_done_cycle", 32'(dk), 32'd9);

        // Back-to-back: start held through DONE launches the next add at once.
        run8(8'h01, 8'h02, 1'b0, s, co, ov, bcyc, k1);
        check("b2b_first_sum", 32'(s), 32'h03);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_restart_done", 32'(done8), 32'd0);
        check("b2b_restart_busy", 32'(busy8), 32'd1);
        stable = 1'b1;
        m = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done8) begin
                m = k;
                break;
            end
            if (sum8 !== 8'h03) stable = 1'b0;
            @(negedge clk);
        end
        check("b2b_sum_held", 32'(stable), 32'd1);
        check("b2b_done_spacing", 32'(m), 32'd9);
        check("b2b_sum", 32'(sum8), 32'h00);
        check("b2b_co", 32'(co8), 32'd1);
        check("b2b_ov", 32'(ov8), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            r8 = ref8(ra, rb, rc);
            run8(ra, rb, rc, s, co, ov, bcyc, dk);
            check($sformatf("rnd8_sum %h+%h+%0d", ra, rb, rc), 32'(s), 32'(r8[7:0]));
            check($sformatf("rnd8_co %h+%h+%0d", ra, rb, rc), 32'(co), 32'(r8[8]));
            check($sformatf("rnd8_ov %h+%h+%0d", ra, rb, rc), 32'(ov), 32'(r8[9]));
            check("rnd8_done_cycle", 32'(dk), 32'd9);
        end

        for (int i = 0; i < 1000; i++) begin
            ra[0] = 1'($urandom);
            rb[0] = 1'($urandom);
            rc    = 1'($urandom);
            r = ref1(ra[0], rb[0], rc);
            run1(ra[0], rb[0], rc, s1, co, ov, bcyc, dk);
            check($sformatf("rnd1_sum %0d+%0d+%0d", ra[0], rb[0], rc), 32'(s1), 32'(r[0]));
            check($sformatf("rnd1_co %0d+%0d+%0d", ra[0], rb[0], rc), 32'(co), 32'(r[1]));
            check($sformatf("rnd1_ov %0d+%0d+%0d", ra[0], rb[0], rc), 32'(ov), 32'(r[2]));
            check("rnd1_busy_cycles", 32'(bcyc), 32'd1);
            check("rnd1_done_cycle", 32'(dk), 32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
